// File: rtl/cook_timer_if.sv
// Operator panel / display bundle of the cook timer: buttons and door level in,
// remaining seconds plus magnetron-enable and finish flags out.
interface cook_timer_if #(
   parameter int CNT_W = 10
);
   logic             add_10min;
   logic             add_1min;
   logic             add_10sec;
   logic             add_1sec;
   logic             start;
   logic             pause;
   logic             cancel;
   logic             door_open;
   logic [CNT_W-1:0] count_down;
   logic             running;
   logic             finish;

   modport master (
      output add_10min, add_1min, add_10sec, add_1sec, start, pause, cancel, door_open,
      input  count_down, running, finish
   );

   modport slave (
      input  add_10min, add_1min, add_10sec, add_1sec, start, pause, cancel, door_open,
      output count_down, running, finish
   );
endinterface

// File: rtl/cook_timer.sv
// Microwave cook-time controller: add buttons, start/pause/cancel, door interlock, prescaled countdown.
// All outputs registered, one-cycle input-to-output latency; no backpressure (level/pulse inputs).
module cook_timer #(
   parameter int CNT_W       = 10,
   parameter int MAX_SEC     = 999,
   parameter int TICK_DIV    = 1,
   parameter int FINISH_HOLD = 0
) (
   input  logic        clk,
   input  logic        rst,
   cook_timer_if.slave tmr
);
   localparam int SW = CNT_W + 2;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (FINISH_HOLD > 1) ? $clog2(FINISH_HOLD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_RUN,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic [PW-1:0]    presc_q;
   logic [HW-1:0]    hold_q;
   logic             running_q;
   logic             finish_q;

   logic             blk_d;
   logic             start_d;
   logic             add_d;
   logic [SW-1:0]    inc_d;
   logic [SW-1:0]    sum_d;
   logic [CNT_W-1:0] new_cnt_d;
   logic [CNT_W-1:0] inc_cnt_d;

   // Pause or an open door outranks start and the add buttons in every state.
   assign blk_d   = tmr.pause | tmr.door_open;
   assign start_d = tmr.start & ~blk_d;
   assign inc_d   = (tmr.add_10min ? SW'(600) : SW'(0)) + (tmr.add_1min ? SW'(60) : SW'(0))
                  + (tmr.add_10sec ? SW'(10)  : SW'(0)) + (tmr.add_1sec ? SW'(1)  : SW'(0));
   assign add_d   = (inc_d != '0) & ~blk_d;
   assign sum_d   = SW'(count_q) + inc_d;
   assign new_cnt_d = (sum_d > SW'(MAX_SEC)) ? CNT_W'(MAX_SEC) : sum_d[CNT_W-1:0];
   assign inc_cnt_d = (inc_d > SW'(MAX_SEC)) ? CNT_W'(MAX_SEC) : inc_d[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst || tmr.cancel) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         presc_q   <= '0;
         hold_q    <= '0;
         running_q <= 1'b0;
         finish_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (add_d) begin
                  count_q <= new_cnt_d;
                  state_q <= S_SET;
               end
            end
            S_SET, S_PAUSED: begin
               if (start_d && count_q != '0) begin
                  state_q   <= S_RUN;
                  running_q <= 1'b1;
               end else if (add_d) begin
                  count_q <= new_cnt_d;
               end
            end
            S_RUN: begin
               if (blk_d) begin
                  state_q   <= S_PAUSED;
                  running_q <= 1'b0;
               end else if (presc_q == PW'(TICK_DIV - 1)) begin
                  presc_q <= '0;
                  count_q <= count_q - CNT_W'(1);
                  if (count_q == CNT_W'(1)) begin
                     state_q   <= S_DONE;
                     running_q <= 1'b0;
                     finish_q  <= 1'b1;
                     hold_q    <= '0;
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            S_DONE: begin
               if (start_d) begin
                  state_q  <= S_IDLE;
                  finish_q <= 1'b0;
               end else if (add_d) begin
                  count_q  <= inc_cnt_d;
                  state_q  <= S_SET;
                  finish_q <= 1'b0;
               end else if (FINISH_HOLD > 0) begin
                  // hold_q counts cycles already spent in DONE after the entry cycle
                  if (hold_q == HW'(FINISH_HOLD - 1)) begin
                     state_q  <= S_IDLE;
                     finish_q <= 1'b0;
                     hold_q   <= '0;
                  end else begin
                     hold_q <= hold_q + HW'(1);
                  end
               end
            end
            default: begin
               state_q   <= S_IDLE;
               running_q <= 1'b0;
               finish_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tmr.count_down = count_q;
   assign tmr.running    = running_q;
   assign tmr.finish     = finish_q;
endmodule
